// File: rtl/single_port_ram_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the single-port RAM burst controller.
// The CLEAR state exists only when RAM_CTRL_CLEAR_EN is defined.
package single_port_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    WRITE = S_WRITE,
    READ  = S_READ,
`ifdef RAM_CTRL_CLEAR_EN
    DRAIN = S_DRAIN,
    CLEAR = S_CLEAR
`else
    DRAIN = S_DRAIN
`endif
  } state_e;

endpackage

// File: rtl/single_port_ram_ctrl_if.sv
// Command, write, read-stream and RAM-side signals of the burst controller.
// RAM_CTRL_CLEAR_EN adds the clr_req/clr_done pair.
interface single_port_ram_ctrl_if #(
  parameter int DATA_W = single_port_ram_pkg::DATA_W_DEF,
  parameter int ADDR_W = single_port_ram_pkg::ADDR_W_DEF,
  parameter int LEN_W  = single_port_ram_pkg::LEN_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              ram_cs;
  logic              ram_wr;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef RAM_CTRL_CLEAR_EN
  logic              clr_req;
  logic              clr_done;
`endif

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
`ifdef RAM_CTRL_CLEAR_EN
    input  clr_req,
    output clr_done,
`endif
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
    output ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_rdata,
`ifdef RAM_CTRL_CLEAR_EN
    output clr_req,
    input  clr_done,
`endif
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy,
    input  ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata
  );
endinterface

// File: rtl/single_port_ram_ctrl_rd_fifo.sv
// Two-entry {last, data} fifo that absorbs read data returned by the RAM.
// Overflow is prevented upstream by the controller's credit rule.
module sp_ram_rd_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o,
  output logic         not_empty_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q;
  logic         rp_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= push_data_i;
        wp_q        <= ~wp_q;
      end
      if (pop_i) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o      = mem_q[rp_q];
  assign count_o     = cnt_q;
  assign not_empty_o = (cnt_q != 2'd0);
endmodule

// File: rtl/single_port_ram_ctrl.sv
// Burst front end for a single-port RAM with 1-cycle registered read latency.
// RAM_CTRL_CLEAR_EN adds a CLEAR state that zero-fills the RAM on clr_req.
//  state | meaning
//  IDLE  | ready for a command (or a clear request)
//  WRITE | one RAM write per accepted write beat
//  READ  | issuing reads while the fifo has credit
//  DRAIN | all reads issued, waiting for the fifo to empty
//  CLEAR | writing zero to every address, one per clk
module single_port_ram_ctrl
  import single_port_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  single_port_ram_ctrl_if.slave bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              alive_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic [1:0]        fifo_count;
  logic              fifo_not_empty;
  logic [DATA_W:0]   fifo_head;

  logic              clr_start;
  logic              clr_beat;
  logic              cmd_ready_w;
  logic              accept;
  logic              pop;
  logic              issue;
  logic              wr_beat;
  logic              step;
  logic              ram_wr_w;
  logic [2:0]        credit;

`ifdef RAM_CTRL_CLEAR_EN
  logic              clr_done_q;
  assign clr_start     = alive_q && (state_q == IDLE) && bus.clr_req;
  assign clr_beat      = (state_q == CLEAR);
  assign bus.clr_done  = clr_done_q;
`else
  assign clr_start     = 1'b0;
  assign clr_beat      = 1'b0;
`endif

  // alive_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready_w = alive_q && (state_q == IDLE) && !clr_start;
  assign accept      = bus.cmd_valid && cmd_ready_w;
  assign pop         = fifo_not_empty && bus.rd_ready;
  assign credit      = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = (state_q == READ) && (credit < 3'd2);
  assign wr_beat     = (state_q == WRITE) && bus.wr_valid;
  assign step        = wr_beat || issue || clr_beat;
  assign ram_wr_w    = wr_beat || clr_beat;

  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (accept) begin
      cur_addr_d  = bus.cmd_addr;
      remaining_d = bus.cmd_len;
    end else if (clr_start) begin
      cur_addr_d  = '0;
    end else if (step) begin
      cur_addr_d  = cur_addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      alive_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
      clr_done_q      <= 1'b0;
`endif
    end else begin
      alive_q         <= 1'b1;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == '0);
`ifdef RAM_CTRL_CLEAR_EN
      clr_done_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
`ifdef RAM_CTRL_CLEAR_EN
          if (clr_start) state_q <= CLEAR;
          else
`endif
          if (accept) state_q <= bus.cmd_wr ? WRITE : READ;
        end
        WRITE: if (wr_beat && (remaining_q == '0)) state_q <= IDLE;
        READ:  if (issue && (remaining_q == '0)) state_q <= DRAIN;
        DRAIN: if ((fifo_count == 2'd0) && !inflight_q) state_q <= IDLE;
`ifdef RAM_CTRL_CLEAR_EN
        CLEAR: begin
          if (&cur_addr_q) begin
            state_q    <= IDLE;
            clr_done_q <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  sp_ram_rd_fifo #(.W(DATA_W + 1)) u_rd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, bus.ram_rdata}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .not_empty_o (fifo_not_empty)
  );

  assign bus.cmd_ready = cmd_ready_w;
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.rd_valid  = fifo_not_empty;
  assign bus.rd_data   = fifo_head[DATA_W-1:0];
  assign bus.rd_last   = fifo_head[DATA_W];
  assign bus.busy      = (state_q != IDLE);
  assign bus.ram_wr    = ram_wr_w;
  assign bus.ram_rd    = issue;
  assign bus.ram_cs    = ram_wr_w || issue;
  assign bus.ram_addr  = cur_addr_q;
  assign bus.ram_wdata = (state_q == WRITE) ? bus.wr_data : '0;
endmodule

// File: tb/tb_single_port_ram_ctrl.sv
// Randomized bench for single_port_ram_ctrl with a behavioural RAM and a queue-based reference.
// The RAM_CTRL_CLEAR_EN section runs only when that macro is defined.
module tb_single_port_ram_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  single_port_ram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

  single_port_ram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port RAM with registered read data
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_rdata_q = '0;
  assign bus.ram_rdata = ram_rdata_q;
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_wr) ram[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_cs && bus.ram_rd) ram_rdata_q <= ram[bus.ram_addr];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wbeat_t;

  logic [DW-1:0] model_mem [DEPTH];
  wbeat_t        exp_w[$];
  logic [DW:0]   exp_r[$];
  logic [AW-1:0] wlog[$];
  logic [DW-1:0] rlog[$];
  logic          lastlog[$];
  int            pop_cyc[$];
  wbeat_t        e_w;
  logic [DW:0]   e_r;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int issued = 0;
  int popped = 0;
  int rd_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0:       bus.rd_ready = 1'b1;
      1:       bus.rd_ready = 1'($urandom_range(0, 1));
      default: bus.rd_ready = cyc[1];
    endcase
  end

  // Per-cycle compare against the expected write and read-stream queues
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("strobe_rule", (bus.ram_cs == (bus.ram_wr | bus.ram_rd)) && !(bus.ram_wr && bus.ram_rd), 1);
      chk("credit_bound", (issued - popped) <= 2, 1);
      if (bus.ram_wr) begin
        wlog.push_back(bus.ram_addr);
        if (exp_w.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e_w = exp_w.pop_front();
          chk("wr_addr", bus.ram_addr, e_w.addr);
          chk("wr_data", bus.ram_wdata, e_w.data);
        end
      end
      if (bus.ram_rd) issued++;
      if (bus.rd_valid && bus.rd_ready) begin
        popped++;
        rlog.push_back(bus.rd_data);
        lastlog.push_back(bus.rd_last);
        pop_cyc.push_back(cyc);
        if (exp_r.size() == 0) chk("unexpected_read_beat", 1, 0);
        else begin
          e_r = exp_r.pop_front();
          chk("rd_data", bus.rd_data, e_r[DW-1:0]);
          chk("rd_last", bus.rd_last, e_r[DW]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l, output bit ok);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !bus.busy;
      tick();
    end
    chk({nm, "_idle_timeout"}, done, 1);
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit gaps, input bit lit);
    logic [DW-1:0] d[$];
    bit ok;
    int n;
    int guard;
    for (int i = 0; i <= int'(l); i++) begin
      d.push_back(lit ? DW'(8'hA0 + i) : DW'($urandom));
      exp_w.push_back('{addr: AW'(int'(a) + i), data: d[i]});
      model_mem[AW'(int'(a) + i)] = d[i];
    end
    send_cmd(1'b1, a, l, ok);
    n = 0;
    guard = 0;
    while (ok && n <= int'(l) && guard < 200) begin
      bus.wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wr_data  = d[n];
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) n++;
      tick();
      guard++;
    end
    bus.wr_valid = 1'b0;
    wait_idle("write");
    chk("wr_beats_left", exp_w.size(), 0);
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit lat);
    bit ok;
    int iss0;
    for (int i = 0; i <= int'(l); i++)
      exp_r.push_back({(i == int'(l)), model_mem[AW'(int'(a) + i)]});
    iss0 = issued;
    send_cmd(1'b0, a, l, ok);
    if (lat) begin
      @(negedge clk);
      chk("rd_first_strobe", {bus.ram_rd, bus.ram_addr}, {1'b1, a});
      tick();
    end
    wait_idle("read");
    chk("rd_beats_left", exp_r.size(), 0);
    chk("rd_issue_count", issued - iss0, int'(l) + 1);
  endtask

  logic [AW-1:0] lit_a [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'h5A;
`ifdef RAM_CTRL_CLEAR_EN
    bus.clr_req   = 1'b0;
`endif
    lit_a[0] = 10'h3FE; lit_a[1] = 10'h3FF; lit_a[2] = 10'h000; lit_a[3] = 10'h001;

    // Reset: every output quiet while rst is low
    repeat (3) begin
      @(negedge clk);
      chk("reset_quiet", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.rd_last,
                          bus.busy, bus.ram_cs, bus.ram_wr, bus.ram_rd, bus.ram_addr, bus.ram_wdata}, 0);
    end
    bus.wr_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    chk("cmd_ready_after_release", bus.cmd_ready, 1);
    tick();

    // Preload the whole RAM so model and RAM agree everywhere
    rd_mode = 0;
    for (int b = 0; b < DEPTH / 16; b++) run_write(AW'(b * 16), 4'hF, 1'b0, 1'b0);

    // Wrapping write burst with literal data
    wlog.delete();
    run_write(10'h3FE, 4'd3, 1'b0, 1'b1);
    chk("wlog_size", wlog.size(), 4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) chk("wrap_addr", wlog[k], lit_a[k]);

    // Read it back at full rate
    rlog.delete(); lastlog.delete(); pop_cyc.delete();
    run_read(10'h3FE, 4'd3, 1'b1);
    chk("rlog_size", rlog.size(), 4);
    for (int k = 0; k < 4 && k < rlog.size(); k++) begin
      chk("burst_data_lit", rlog[k], 8'hA0 + k);
      chk("burst_last_lit", lastlog[k], k == 3);
      chk("burst_back_to_back", pop_cyc[k] - pop_cyc[0], k);
    end

    // Single-beat burst
    run_read(10'h3FF, 4'd0, 1'b1);

    // Backpressure: rd_ready toggles every 2 clk
    rd_mode = 2;
    run_read(10'h010, 4'd7, 1'b0);

    // Asynchronous reset in the middle of a read burst
    begin
      bit ok;
      rd_mode = 0;
      for (int i = 0; i <= 7; i++) exp_r.push_back({(i == 7), model_mem[AW'(10'h100 + i)]});
      send_cmd(1'b0, 10'h100, 4'd7, ok);
      repeat (2) tick();
      #2 rst = 1'b0;
      #1;
      chk("async_reset_quiet", {bus.busy, bus.rd_valid, bus.ram_cs, bus.ram_rd, bus.cmd_ready}, 0);
      exp_r.delete();
      issued = 0;
      popped = 0;
      tick();
      rst = 1'b1;
      tick();
      run_read(10'h100, 4'd7, 1'b1);
      run_write(10'h200, 4'd2, 1'b1, 1'b0);
    end

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      rd_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) run_write(AW'($urandom), LW'($urandom), 1'b1, 1'b0);
      else                           run_read(AW'($urandom), LW'($urandom), 1'b0);
    end

`ifdef RAM_CTRL_CLEAR_EN
    begin
      bit seen;
      rd_mode = 0;
      for (int i = 0; i < DEPTH; i++) begin
        exp_w.push_back('{addr: AW'(i), data: '0});
        model_mem[i] = '0;
      end
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < DEPTH + 20 && !seen; i++) begin
        @(negedge clk);
        seen = bus.clr_done;
        tick();
      end
      chk("clr_done_seen", seen, 1);
      chk("clr_writes_left", exp_w.size(), 0);
      rlog.delete();
      run_read(10'd5, 4'd0, 1'b1);
      chk("clr_read_zero", (rlog.size() == 1) ? rlog[0] : 8'hFF, 0);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
